// File: rtl/rc_scheduler.sv
// rc_scheduler: round-robin sharing of one routing-computation unit among input-VC requesters
// Ports: clk/rst (async active-high); req_vec/headers from VC buffers;
//        grant_vec/done/res_outport_vec/res_allow_vcs result to winner; busy status;
//        rc_req/rc_header to RC unit; rc_outport_vec/rc_allow_vcs/rc_valid from RC unit.
module rc_scheduler #(
    parameter int no_req = 13,
    parameter int floorplusone_log2_no_req = 4,
    parameter int no_outport = 6,
    parameter int no_vc = 13,
    parameter int flit_size = 1,
    parameter int phit_size = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [no_req-1:0]                     req_vec,
    input  logic [no_req*flit_size*phit_size-1:0] headers,
    output logic [no_req-1:0]                     grant_vec,
    output logic                                  done,
    output logic [no_outport-1:0]                 res_outport_vec,
    output logic [no_vc-1:0]                      res_allow_vcs,
    output logic                                  busy,
    output logic                                  rc_req,
    output logic [flit_size*phit_size-1:0]        rc_header,
    input  logic [no_outport-1:0]                 rc_outport_vec,
    input  logic [no_vc-1:0]                      rc_allow_vcs,
    input  logic                                  rc_valid
);
    localparam int H = flit_size * phit_size;
    localparam int W = floorplusone_log2_no_req;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   rr_ptr, winner, win_idx;
    logic [W:0]     s;
    logic [H-1:0]   hdr_reg;
    logic           served;

    assign served    = state == WAIT && rc_valid;
    assign rc_req    = state == ISSUE;
    assign busy      = state != IDLE;
    assign rc_header = hdr_reg;

    // Scan downward so the lowest offset from rr_ptr is assigned last and wins.
    always_comb begin
        win_idx = '0;
        s = '0;
        for (int i = no_req - 1; i >= 0; i--) begin
            s = {1'b0, rr_ptr} + (W+1)'(i);
            s = (s >= (W+1)'(no_req)) ? s - (W+1)'(no_req) : s;
            if (req_vec[s[W-1:0]]) win_idx = s[W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE)  ? ((|req_vec) ? ISSUE : IDLE) :
                    (state == ISSUE) ? WAIT :
                    (rc_valid ? IDLE : WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            winner          <= '0;
            hdr_reg         <= '0;
            done            <= 1'b0;
            grant_vec       <= '0;
            res_outport_vec <= '0;
            res_allow_vcs   <= '0;
        end else begin
            done      <= served;
            grant_vec <= served ? {{(no_req-1){1'b0}}, 1'b1} << winner : '0;
            if (state == IDLE && |req_vec) begin
                winner  <= win_idx;
                hdr_reg <= headers[win_idx*H +: H];
            end
            if (served) begin
                res_outport_vec <= rc_outport_vec;
                res_allow_vcs   <= rc_allow_vcs;
                rr_ptr          <= (winner == W'(no_req - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rc_scheduler.sv
// tb_rc_scheduler: scoreboard bench for rc_scheduler with a one-cycle RC unit model
module tb_rc_scheduler;
    localparam int N = 13;
    localparam int H = 16;

    typedef struct {
        logic [N-1:0] g;
        logic [5:0]   o;
        logic [12:0]  a;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vec;
    logic [N*H-1:0] headers;
    logic [N-1:0]   grant_vec;
    logic           done;
    logic [5:0]     res_outport_vec;
    logic [12:0]    res_allow_vcs;
    logic           busy;
    logic           rc_req;
    logic [H-1:0]   rc_header;
    logic [5:0]     rc_outport_vec = '0;
    logic [12:0]    rc_allow_vcs = '0;
    logic           rc_valid = 1'b0;

    exp_t q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    logic auto_drop = 1'b1;

    rc_scheduler dut (
        .clk(clk), .rst(rst), .req_vec(req_vec), .headers(headers),
        .grant_vec(grant_vec), .done(done), .res_outport_vec(res_outport_vec),
        .res_allow_vcs(res_allow_vcs), .busy(busy), .rc_req(rc_req),
        .rc_header(rc_header), .rc_outport_vec(rc_outport_vec),
        .rc_allow_vcs(rc_allow_vcs), .rc_valid(rc_valid)
    );

    always #5 clk = ~clk;

    // RC unit model: route field hdr[11:8] picks the output port, hdr[15:12] trims the VC mask.
    function automatic logic [5:0] rc_out(input logic [15:0] h);
        return 6'd1 << (h[11:8] % 4'd6);
    endfunction

    function automatic logic [12:0] rc_allow(input logic [15:0] h);
        return 13'h1FFF >> h[15:12];
    endfunction

    always @(posedge clk) begin
        rc_valid <= rc_req;
        if (rc_req) begin
            rc_outport_vec <= rc_out(rc_header);
            rc_allow_vcs   <= rc_allow(rc_header);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int i);
        logic [15:0] h;
        h = headers[i*H +: H];
        q.push_back('{N'(1) << i, rc_out(h), rc_allow(h)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop && done) req_vec = req_vec & ~grant_vec;
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
        check(name, n, exp_n);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_done: got grant %0h expected no done", grant_vec);
            end else begin
                mon_e = q.pop_front();
                check("grant_vec", 32'(grant_vec), 32'(mon_e.g));
                check("res_outport_vec", 32'(res_outport_vec), 32'(mon_e.o));
                check("res_allow_vcs", 32'(res_allow_vcs), 32'(mon_e.a));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req_vec = '0;
        headers = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_grant", grant_vec, 0);
        check("rst_busy", busy, 0);
        check("rst_rc_req", rc_req, 0);
        check("rst_rc_header", rc_header, 0);
        check("rst_res_out", res_outport_vec, 0);
        check("rst_res_allow", res_allow_vcs, 0);
        rst = 1'b0;

        // single request, hand-computed RC response
        headers[2*H +: H] = 16'h0123;
        q.push_back('{13'h0004, 6'b000010, 13'h1FFF});
        req_vec = 13'h0004;
        tick();
        check("issue_rc_req", rc_req, 1);
        check("issue_rc_header", rc_header, 16'h0123);
        check("issue_busy", busy, 1);
        tick();
        check("wait_rc_req", rc_req, 0);
        tick();
        check("single_done", done, 1);
        tick();
        check("done_pulse_end", done, 0);
        check("idle_busy", busy, 0);

        // move rr_ptr away from 0, then reset during WAIT
        headers[5*H +: H] = 16'h2345;
        push(5);
        req_vec = 13'h0020;
        wait_done("lat_req5", 3);
        headers[7*H +: H] = 16'h0777;
        req_vec = 13'h0080;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_rc_req", rc_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_grant", grant_vec, 0);
        check("midrst_rc_header", rc_header, 0);
        check("midrst_res_out", res_outport_vec, 0);
        req_vec = '0;
        tick();
        tick();
        rst = 1'b0;

        // pointer back at 0: req 0 beats req 7, then back-to-back service of 7
        headers[0 +: H] = 16'h0510;
        push(0);
        push(7);
        req_vec = 13'h0081;
        wait_done("lat_after_rst", 3);
        wait_done("lat_back_to_back", 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // full round robin
        for (int i = 0; i < N; i++) begin
            headers[i*H +: H] = 16'(i) * 16'h1111;
            push(i);
        end
        req_vec = '1;
        for (int i = 0; i < N; i++) wait_done("rr_spacing", 3);

        // wrap: serve 11 so rr_ptr=12, then 12 before 0, then pointer at 1
        push(11);
        req_vec = 13'h0800;
        wait_done("lat_req11", 3);
        push(12);
        push(0);
        req_vec = 13'h1001;
        wait_done("wrap_12", 3);
        wait_done("wrap_0", 3);
        push(1);
        push(0);
        req_vec = 13'h0003;
        wait_done("ptr1_first", 3);
        wait_done("ptr1_second", 3);

        // header change after latch is ignored
        headers[4*H +: H] = 16'h4352;
        push(4);
        req_vec = 13'h0010;
        tick();
        headers[4*H +: H] = 16'h0A00;
        #1;
        check("hdr_stable_issue", rc_header, 16'h4352);
        tick();
        check("hdr_stable_wait", rc_header, 16'h4352);
        tick();
        check("hdr_done", done, 1);

        // winner drops req during WAIT
        tick();
        auto_drop = 1'b0;
        headers[6*H +: H] = 16'h1600;
        push(6);
        req_vec = 13'h0040;
        tick();
        tick();
        req_vec = '0;
        tick();
        check("drop_done", done, 1);
        tick();
        check("drop_no_rearb", busy, 0);
        repeat (3) tick();
        check("drop_idle", busy, 0);
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
